// File: rtl/z80_reset_sequencer.sv
// z80_reset_sequencer
// Generates the divided Z80 clock and drives the Z80 /RESET pin.
// /RESET is held low for HOLD_CYCLES complete Z80 clock periods after
// power-on (i_reset_n) or after a debounced front-panel button press.
// It is released on a falling edge of the Z80 clock.
// Optional feature macro: BUTTON_RESET_EN. When it is undefined, the
// button path is not built and only the power-on sequence runs.
module z80_reset_sequencer #(
  parameter int CLK_DIV        = 4,
  parameter int CLK_DIV_WIDTH  = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int HOLD_WIDTH     = 4,
  parameter int DEBOUNCE_COUNT = 50000,
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_button_n,
  output logic o_z80_clk,
  output logic o_z80_reset_n,
  output logic o_ready
);

  localparam logic [CLK_DIV_WIDTH-1:0] DIV_HALF_M1 = CLK_DIV_WIDTH'(CLK_DIV / 2 - 1);
  localparam logic [CLK_DIV_WIDTH-1:0] DIV_LAST    = CLK_DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [HOLD_WIDTH-1:0]    HOLD_LAST   = HOLD_WIDTH'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  logic [CLK_DIV_WIDTH-1:0] div_cnt_q;
  logic [CLK_DIV_WIDTH-1:0] div_cnt_d;
  logic                     z80_clk_q;
  logic                     period_done_s;

  state_e                   state_q;
  logic [HOLD_WIDTH-1:0]    hold_cnt_q;
  logic                     z80_reset_n_q;
  logic                     ready_q;

  logic                     btn_stable_s;
  logic                     press_s;

  // Divider next-state: free-running count that wraps at the end of a Z80 period
  always_comb begin
    period_done_s = (div_cnt_q == DIV_LAST);
    if (period_done_s) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CLK_DIV_WIDTH'(1);
    end
  end

  // Divider and Z80 clock: rises mid-period, falls on period completion
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      div_cnt_q <= '0;
      z80_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      if (div_cnt_q == DIV_HALF_M1) begin
        z80_clk_q <= 1'b1;
      end else if (period_done_s) begin
        z80_clk_q <= 1'b0;
      end else begin
        z80_clk_q <= z80_clk_q;
      end
    end
  end

`ifdef BUTTON_RESET_EN
  localparam logic [DEBOUNCE_WIDTH-1:0] DEB_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_COUNT - 1);

  logic                      sync1_q;
  logic                      sync2_q;
  logic [DEBOUNCE_WIDTH-1:0] deb_cnt_q;
  logic                      btn_stable_q;
  logic                      stable_dly_q;
  logic                      press_q;

  // Button path: synchronise, debounce, and flag the press (1->0 of stable level)
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      deb_cnt_q    <= '0;
      btn_stable_q <= 1'b1;
      stable_dly_q <= 1'b1;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= i_button_n;
      sync2_q      <= sync1_q;
      if (sync2_q != btn_stable_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          btn_stable_q <= sync2_q;
          deb_cnt_q    <= '0;
        end else begin
          deb_cnt_q    <= deb_cnt_q + DEBOUNCE_WIDTH'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
      stable_dly_q <= btn_stable_q;
      press_q      <= stable_dly_q & ~btn_stable_q;
    end
  end

  assign btn_stable_s = btn_stable_q;
  assign press_s      = press_q;
`else
  // Button input is deliberately ignored in this build.
  logic                      unused_btn_s;
  logic [DEBOUNCE_WIDTH-1:0] unused_deb_s;

  assign unused_btn_s = i_button_n;
  assign unused_deb_s = DEBOUNCE_WIDTH'(DEBOUNCE_COUNT);
  assign btn_stable_s = 1'b1;
  assign press_s      = 1'b0;
`endif

  // Reset FSM: counts completed Z80 periods in HOLD, releases /RESET on the last one
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= ST_HOLD;
      hold_cnt_q    <= '0;
      z80_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          z80_reset_n_q <= 1'b0;
          ready_q       <= 1'b0;
          if (press_s || !btn_stable_s) begin
            // Press beats a coincident final completion; a held button freezes the count
            hold_cnt_q <= '0;
          end else if (period_done_s) begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_q       <= ST_RUN;
              hold_cnt_q    <= '0;
              z80_reset_n_q <= 1'b1;
              ready_q       <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_WIDTH'(1);
            end
          end else begin
            hold_cnt_q <= hold_cnt_q;
          end
        end
        ST_RUN: begin
          if (press_s) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            z80_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
          end else begin
            z80_reset_n_q <= 1'b1;
            ready_q       <= 1'b1;
          end
        end
        default: begin
          state_q       <= ST_HOLD;
          hold_cnt_q    <= '0;
          z80_reset_n_q <= 1'b0;
          ready_q       <= 1'b0;
        end
      endcase
    end
  end

  assign o_z80_clk     = z80_clk_q;
  assign o_z80_reset_n = z80_reset_n_q;
  assign o_ready       = ready_q;

endmodule

// File: tb/tb_z80_reset_sequencer.sv
// Testbench for z80_reset_sequencer (CLK_DIV=4, HOLD_CYCLES=4, DEBOUNCE_COUNT=8).
// Works with or without BUTTON_RESET_EN; button scenarios run only when it is defined.
module tb_z80_reset_sequencer;

  localparam int CLK_DIV = 4;
  localparam int HOLD_CYCLES = 4;
  localparam int DEB = 8;
`ifdef BUTTON_RESET_EN
  localparam bit BTN_EN = 1'b1;
`else
  localparam bit BTN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic i_reset_n;
  logic i_button_n;
  logic o_z80_clk;
  logic o_z80_reset_n;
  logic o_ready;

  int checks = 0;
  int errors = 0;

  z80_reset_sequencer #(
    .CLK_DIV(CLK_DIV), .CLK_DIV_WIDTH(3), .HOLD_CYCLES(HOLD_CYCLES), .HOLD_WIDTH(4),
    .DEBOUNCE_COUNT(DEB), .DEBOUNCE_WIDTH(16)
  ) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_button_n(i_button_n),
    .o_z80_clk(o_z80_clk), .o_z80_reset_n(o_z80_reset_n), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  // Reference model state, expressed in edges since reset release and event times
  int   m_t;
  logic m_s1, m_s2, m_stable;
  int   m_run;
  int   m_fall_t;
  logic m_hold;
  int   m_ncomp;
  logic m_clk, m_rstn, m_ready;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (model t=%0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic model_update(input logic rst, input logic btn);
    logic sync_seen;
    logic stable_old;
    bit   comp;
    bit   press_eff;
    if (!rst) begin
      m_t = 0; m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1; m_run = 0;
      m_fall_t = -100; m_hold = 1'b1; m_ncomp = 0;
      m_clk = 1'b0; m_rstn = 1'b0; m_ready = 1'b0;
    end else begin
      m_t++;
      stable_old = m_stable;
      comp      = (m_t % CLK_DIV) == 0;
      press_eff = (m_t == m_fall_t + 2);
      m_clk     = (m_t % CLK_DIV) >= CLK_DIV / 2;
      if (m_hold) begin
        if (press_eff || !stable_old) begin
          m_ncomp = 0;
        end else if (comp) begin
          m_ncomp++;
          if (m_ncomp == HOLD_CYCLES) begin
            m_hold = 1'b0; m_rstn = 1'b1; m_ready = 1'b1; m_ncomp = 0;
          end
        end
      end else if (press_eff) begin
        m_hold = 1'b1; m_ncomp = 0; m_rstn = 1'b0; m_ready = 1'b0;
      end
      if (BTN_EN) begin
        sync_seen = m_s2;
        m_s2 = m_s1;
        m_s1 = btn;
        if (sync_seen != m_stable) begin
          m_run++;
          if (m_run == DEB) begin
            m_stable = sync_seen;
            m_run = 0;
            if (!sync_seen) m_fall_t = m_t;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic btn);
    i_reset_n  = rst;
    i_button_n = btn;
    @(posedge clk);
    #1;
    model_update(rst, btn);
    chk("model_z80_clk", o_z80_clk, m_clk);
    chk("model_z80_reset_n", o_z80_reset_n, m_rstn);
    chk("model_ready", o_ready, m_ready);
  endtask

  typedef struct {
    logic rst_n;
    logic btn_n;
    logic e_clk;
    logic e_rstn;
    logic e_ready;
  } vec_t;

  vec_t tbl[23];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int left;
    logic lvl;

    // Power-on: 5 reset cycles then edges t=1..18 after release
    tbl = '{
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1}, '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1}
    };

    i_reset_n  = 1'b0;
    i_button_n = 1'b1;
    m_t = 0;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rst_n, tbl[i].btn_n);
      chk("tbl_z80_clk", o_z80_clk, tbl[i].e_clk);
      chk("tbl_z80_reset_n", o_z80_reset_n, tbl[i].e_rstn);
      chk("tbl_ready", o_ready, tbl[i].e_ready);
    end

`ifdef BUTTON_RESET_EN
    // Button held 20 cycles while running: fall latency and release window
    n = 0;
    do begin
      step(1'b1, 1'b0);
      n++;
    end while (o_z80_reset_n && n < 40);
    chk_int("press_latency", n, 12, 12);
    for (int i = n; i < 20; i++) step(1'b1, 1'b0);
    chk("held_reset_low", o_z80_reset_n, 1'b0);
    n = 0;
    do begin
      step(1'b1, 1'b1);
      n++;
    end while (!o_z80_reset_n && n < 60);
    chk_int("release_window", n, 23, 26);
    chk("release_on_fall", o_z80_clk, 1'b0);

    // Bounce of 5 cycles: no press
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      if (!o_z80_reset_n || !o_ready) bad++;
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1);
      if (!o_z80_reset_n || !o_ready) bad++;
    end
    chk_int("bounce_ignored", bad, 0, 0);
`endif

    // One-cycle reset mid-RUN restarts the full sequence
    step(1'b0, 1'b1);
    chk("midreset_clk", o_z80_clk, 1'b0);
    chk("midreset_rstn", o_z80_reset_n, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b1);
      if (k == 15) chk("midreset_edge15", o_z80_reset_n, 1'b0);
      if (k == 16) chk("midreset_edge16", o_z80_reset_n, 1'b1);
    end

`ifdef BUTTON_RESET_EN
    // Press lands on the 4th period completion of the power-on hold
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, (k >= 5) ? 1'b0 : 1'b1);
      if (k == 16) chk("coincide_stay_hold", o_z80_reset_n, 1'b0);
      if (k == 30) chk("coincide_still_held", o_z80_reset_n, 1'b0);
    end
    n = 0;
    do begin
      step(1'b1, 1'b1);
      n++;
    end while (!o_z80_reset_n && n < 60);
    chk("coincide_recovers", o_z80_reset_n, 1'b1);

    // Randomised button segments with occasional resets, checked against the model
    left = 0;
    lvl  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b0, lvl);
      end else begin
        if (left == 0) begin
          lvl  = ~lvl;
          left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : int'($urandom_range(10, 60));
        end
        left--;
        step(1'b1, lvl);
      end
    end
`else
    // Button is ignored: toggle it freely after power-on
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      if (!o_z80_reset_n || !o_ready) bad++;
    end
    chk_int("button_ignored", bad, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
